// File: rtl/eqed_inject_if.sv
// Bus bundle between an E-QED injection controller and whatever drives it.
// The driver (bench or test sequencer) uses the master view. The controller
// uses the slave view.
// WIN_W and CNT_W are passed in by the instantiator. They must match the
// controller's $clog2(WINDOW+1) and inj_count width.
interface eqed_inject_if #(
  parameter int NUM_FF = 8,
  parameter int SEL_W  = 4,
  parameter int MISR_W = 6,
  parameter int IN_W   = 2,
  parameter int OUT_W  = 3,
  parameter int WIN_W  = 3,
  parameter int CNT_W  = 1
);

  logic              start;
  logic              inj_req;
  logic [SEL_W-1:0]  inj_sel;
  logic [IN_W-1:0]   in_data;
  logic [OUT_W-1:0]  out_data;
  logic [MISR_W-1:0] exp_in_sig;
  logic [MISR_W-1:0] exp_out_sig;
  logic [NUM_FF-1:0] flip;
  logic [MISR_W-1:0] in_sig;
  logic [MISR_W-1:0] out_sig;
  logic              busy;
  logic              done;
  logic              match;
  logic [CNT_W-1:0]  inj_count;
  logic [WIN_W-1:0]  win_cnt;

  modport master (
    output start, inj_req, inj_sel, in_data, out_data, exp_in_sig, exp_out_sig,
    input  flip, in_sig, out_sig, busy, done, match, inj_count, win_cnt
  );

  modport slave (
    input  start, inj_req, inj_sel, in_data, out_data, exp_in_sig, exp_out_sig,
    output flip, in_sig, out_sig, busy, done, match, inj_count, win_cnt
  );

endinterface

// File: rtl/eqed_inject_ctrl.sv
// E-QED fault-injection and signature-capture controller.
//
// The controller drives one-hot bit-flip selects into NUM_FF inverting muxes
// that sit ahead of the checked module's flip-flops. Over a WINDOW-cycle run,
// it compacts the module's input and output streams into two MISRs. At the
// end of the run it compares both signatures against the expected values.
//
// Build option EQED_MULTI_INJECT_EN:
//   - Defined: up to MAX_INJ flips per run, at most one per cycle.
//   - Undefined: exactly one flip per run, and inj_count is one bit wide.
module eqed_inject_ctrl #(
  parameter int                NUM_FF  = 8,
  parameter int                SEL_W   = 4,
  parameter int                MISR_W  = 6,
  parameter int                IN_W    = 2,
  parameter int                OUT_W   = 3,
  parameter logic [MISR_W-1:0] POLY    = 6'h03,
  parameter logic [MISR_W-1:0] SEED    = 6'h01,
  parameter int                WINDOW  = 5,
  parameter int                MAX_INJ = 1
) (
  input  logic         clk,
  input  logic         rst,
  eqed_inject_if.slave bus
);

`ifdef EQED_MULTI_INJECT_EN
  localparam int LIMIT = MAX_INJ;
  localparam int CNT_W = (MAX_INJ < 1) ? 1 : $clog2(MAX_INJ + 1);
`else
  // Single-flip build: the limit is pinned at one whatever MAX_INJ says.
  localparam int LIMIT = (MAX_INJ != 1) ? 1 : MAX_INJ;
  localparam int CNT_W = 1;
`endif

  localparam int WIN_W = $clog2(WINDOW + 1);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
  localparam logic [WIN_W-1:0] LAST_C  = WIN_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One MISR compression step: shift left, fold the tapped feedback back in
  // when the MSB falls off, then xor in the (zero-extended) new data word.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                  input logic [MISR_W-1:0] d);
    return {m[MISR_W-2:0], 1'b0} ^ (m[MISR_W-1] ? POLY : '0) ^ d;
  endfunction

  // Injection counter increment that never passes the per-run limit.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c >= LIMIT_C) ? c : c + 1'b1;
  endfunction

  state_t            state_q;
  logic [MISR_W-1:0] in_sig_q;
  logic [MISR_W-1:0] out_sig_q;
  logic [MISR_W-1:0] in_sig_d;
  logic [MISR_W-1:0] out_sig_d;
  logic [WIN_W-1:0]  win_cnt_q;
  logic [CNT_W-1:0]  inj_count_q;
  logic              busy_q;
  logic              done_q;
  logic              match_q;
  logic              inj_ok;
  logic [NUM_FF-1:0] flip_w;

  // Next MISR values, used both for the RUN update and the final compare.
  always_comb begin
    in_sig_d  = misr_step(in_sig_q,  MISR_W'(bus.in_data));
    out_sig_d = misr_step(out_sig_q, MISR_W'(bus.out_data));
  end

  // Zero-latency one-hot flip decode. An out-of-range select matches no bit,
  // so it produces no flip.
  always_comb begin
    flip_w = '0;
    inj_ok = (state_q == RUN) && bus.inj_req && (inj_count_q < LIMIT_C);
    for (int i = 0; i < NUM_FF; i++) begin
      if (inj_ok && (bus.inj_sel == SEL_W'(i))) begin
        flip_w[i] = 1'b1;
      end
    end
  end

  // Run FSM: seeds the MISRs on start, compacts for WINDOW cycles, then
  // latches the signature compare result and holds until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_sig_q    <= SEED;
      out_sig_q   <= SEED;
      win_cnt_q   <= '0;
      inj_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q     <= RUN;
            in_sig_q    <= SEED;
            out_sig_q   <= SEED;
            win_cnt_q   <= '0;
            inj_count_q <= '0;
            match_q     <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        RUN: begin
          in_sig_q  <= in_sig_d;
          out_sig_q <= out_sig_d;
          win_cnt_q <= win_cnt_q + 1'b1;
          if (|flip_w) begin
            inj_count_q <= cnt_inc(inj_count_q);
          end
          if (win_cnt_q == LAST_C) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            match_q <= (in_sig_d == bus.exp_in_sig) && (out_sig_d == bus.exp_out_sig);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flip      = flip_w;
  assign bus.in_sig    = in_sig_q;
  assign bus.out_sig   = out_sig_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.match     = match_q;
  assign bus.inj_count = inj_count_q;
  assign bus.win_cnt   = win_cnt_q;

endmodule

// File: tb/tb_eqed_inject_ctrl.sv
// Bench for eqed_inject_ctrl.
// The driver issues cycle-level stimulus and pushes the expected outputs into
// queues. These expectations come from a history-based model: a signature is
// the fold of all data words seen since start. A monitor pops and compares
// the per-cycle outputs at every falling edge, and the final run results each
// time done rises.
module tb_eqed_inject_ctrl;

  localparam int NUM_FF = 8;
  localparam int SEL_W  = 4;
  localparam int MISR_W = 6;
  localparam int IN_W   = 2;
  localparam int OUT_W  = 3;
  localparam int WINDOW = 5;
  localparam logic [MISR_W-1:0] POLY = 6'h03;
  localparam logic [MISR_W-1:0] SEED = 6'h01;
`ifdef EQED_MULTI_INJECT_EN
  localparam int MAX_INJ = 3;
  localparam int LIMIT   = 3;
  localparam int CNT_W   = 2;
`else
  localparam int MAX_INJ = 1;
  localparam int LIMIT   = 1;
  localparam int CNT_W   = 1;
`endif
  localparam int WIN_W = $clog2(WINDOW + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eqed_inject_if #(.NUM_FF(NUM_FF), .SEL_W(SEL_W), .MISR_W(MISR_W), .IN_W(IN_W),
                   .OUT_W(OUT_W), .WIN_W(WIN_W), .CNT_W(CNT_W)) ifc ();

  eqed_inject_ctrl #(.NUM_FF(NUM_FF), .SEL_W(SEL_W), .MISR_W(MISR_W), .IN_W(IN_W),
                     .OUT_W(OUT_W), .POLY(POLY), .SEED(SEED), .WINDOW(WINDOW),
                     .MAX_INJ(MAX_INJ)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  typedef struct {
    logic [NUM_FF-1:0] flip;
    logic              busy;
    logic              done;
    logic              match;
    logic [MISR_W-1:0] isig;
    logic [MISR_W-1:0] osig;
    logic [31:0]       win;
    logic [31:0]       cnt;
  } cyc_exp_t;

  typedef struct {
    logic [MISR_W-1:0] isig;
    logic [MISR_W-1:0] osig;
    logic              match;
  } run_exp_t;

  cyc_exp_t cq[$];
  run_exp_t rq[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  // Reference model state: phase 0 idle, 1 running, 2 done; data histories
  int                mst;
  logic [MISR_W-1:0] ih[$];
  logic [MISR_W-1:0] oh[$];
  int                mcnt;
  logic              mmatch;

  // Per-run stimulus arrays, indexed by RUN cycle
  logic [IN_W-1:0]  s_di[WINDOW];
  logic [OUT_W-1:0] s_do[WINDOW];
  bit               s_rq[WINDOW];
  logic [SEL_W-1:0] s_sel[WINDOW];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Signature = seed folded with every data word in order, using plain
  // integer arithmetic: multiply by x, reduce by x^W + POLY, add data.
  function automatic logic [MISR_W-1:0] sig_of(input logic [MISR_W-1:0] d[$]);
    int unsigned m;
    int unsigned top;
    m   = SEED;
    top = 1 << MISR_W;
    foreach (d[i]) begin
      m = m * 2;
      if (m >= top) m = (m - top) ^ POLY;
      m = m ^ d[i];
    end
    return MISR_W'(m);
  endfunction

  function automatic void model_reset();
    mst = 0;
    ih.delete();
    oh.delete();
    mcnt   = 0;
    mmatch = 1'b0;
  endfunction

  // Drive one cycle, record what the DUT must show during it, advance model.
  task automatic cyc(input bit r, input bit s, input bit q, input logic [SEL_W-1:0] sel,
                     input logic [IN_W-1:0] di, input logic [OUT_W-1:0] dout);
    cyc_exp_t e;
    run_exp_t f;
    logic [NUM_FF-1:0] fx;
    rst          = r;
    ifc.start    = s;
    ifc.inj_req  = q;
    ifc.inj_sel  = sel;
    ifc.in_data  = di;
    ifc.out_data = dout;
    fx = '0;
    if (mst == 1 && q && sel < NUM_FF && mcnt < LIMIT) fx = NUM_FF'(1) << sel;
    e.flip  = fx;
    e.busy  = (mst == 1);
    e.done  = (mst == 2);
    e.match = mmatch;
    e.isig  = sig_of(ih);
    e.osig  = sig_of(oh);
    e.win   = ih.size();
    e.cnt   = mcnt;
    cq.push_back(e);
    if (r) begin
      model_reset();
    end else if (mst == 1) begin
      ih.push_back(MISR_W'(di));
      oh.push_back(MISR_W'(dout));
      if (fx != '0) mcnt++;
      if (ih.size() == WINDOW) begin
        mst    = 2;
        mmatch = (sig_of(ih) == ifc.exp_in_sig) && (sig_of(oh) == ifc.exp_out_sig);
        f.isig  = sig_of(ih);
        f.osig  = sig_of(oh);
        f.match = mmatch;
        rq.push_back(f);
      end
    end else if (s) begin
      ih.delete();
      oh.delete();
      mcnt   = 0;
      mmatch = 1'b0;
      mst    = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int req_pct, input int sel_max);
    for (int i = 0; i < WINDOW; i++) begin
      s_di[i]  = IN_W'($urandom);
      s_do[i]  = OUT_W'($urandom);
      s_rq[i]  = ($urandom_range(0, 99) < req_pct);
      s_sel[i] = SEL_W'($urandom_range(0, sel_max));
    end
  endtask

  // Start cycle, WINDOW RUN cycles from the arrays, then one cycle with a
  // request that must not flip (DONE, or IDLE after an abort).
  task automatic run_exec(input logic [MISR_W-1:0] bad_in, input logic [MISR_W-1:0] bad_out,
                          input bit start_noise, input int abort_at);
    logic [MISR_W-1:0] dq[$];
    logic [MISR_W-1:0] oq[$];
    for (int i = 0; i < WINDOW; i++) begin
      dq.push_back(MISR_W'(s_di[i]));
      oq.push_back(MISR_W'(s_do[i]));
    end
    ifc.exp_in_sig  = sig_of(dq) ^ bad_in;
    ifc.exp_out_sig = sig_of(oq) ^ bad_out;
    cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, NUM_FF - 1)),
        IN_W'($urandom), OUT_W'($urandom));
    for (int i = 0; i < WINDOW; i++) begin
      cyc(i == abort_at, start_noise ? 1'($urandom_range(0, 1)) : 1'b0,
          s_rq[i], s_sel[i], s_di[i], s_do[i]);
    end
    cyc(1'b0, 1'b0, 1'b1, SEL_W'($urandom_range(0, NUM_FF - 1)), IN_W'($urandom), OUT_W'($urandom));
  endtask

  // Monitor: per-cycle outputs every falling edge, final results on done rise
  initial begin
    cyc_exp_t e;
    run_exp_t f;
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (cq.size() > 0) begin
          e = cq.pop_front();
          chk("flip",      32'(ifc.flip),      32'(e.flip));
          chk("busy",      32'(ifc.busy),      32'(e.busy));
          chk("done",      32'(ifc.done),      32'(e.done));
          chk("match",     32'(ifc.match),     32'(e.match));
          chk("in_sig",    32'(ifc.in_sig),    32'(e.isig));
          chk("out_sig",   32'(ifc.out_sig),   32'(e.osig));
          chk("win_cnt",   32'(ifc.win_cnt),   e.win);
          chk("inj_count", 32'(ifc.inj_count), e.cnt);
        end
        if (ifc.done === 1'b1 && done_prev !== 1'b1) begin
          if (rq.size() == 0) begin
            chk("done_without_run", 32'd1, 32'd0);
          end else begin
            f = rq.pop_front();
            chk("final_in_sig",  32'(ifc.in_sig),  32'(f.isig));
            chk("final_out_sig", 32'(ifc.out_sig), 32'(f.osig));
            chk("final_match",   32'(ifc.match),   32'(f.match));
          end
        end
        done_prev = ifc.done;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    ifc.start       = 1'b0;
    ifc.inj_req     = 1'b0;
    ifc.inj_sel     = '0;
    ifc.in_data     = '0;
    ifc.out_data    = '0;
    ifc.exp_in_sig  = '0;
    ifc.exp_out_sig = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    mon_en = 1'b1;

    // Reset state, with a request held in IDLE
    cyc(1'b1, 1'b0, 1'b1, SEL_W'(3), '0, '0);
    cyc(1'b0, 1'b0, 1'b1, SEL_W'(3), '0, '0);

    // Single flip at RUN cycle 2 (sel 5); a second request at cycle 3 is blocked
    fill(0, NUM_FF - 1);
    s_rq[2] = 1'b1; s_sel[2] = SEL_W'(5);
    s_rq[3] = 1'b1; s_sel[3] = SEL_W'(2);
    run_exec('0, '0, 1'b0, -1);

    // Out-of-range selects on every cycle
    fill(100, NUM_FF - 1);
    for (int i = 0; i < WINDOW; i++) s_sel[i] = SEL_W'(NUM_FF + (i % 8));
    run_exec('0, '0, 1'b0, -1);

    // One-bit output signature mismatch, then a repeat start from DONE
    fill(0, NUM_FF - 1);
    run_exec('0, MISR_W'(1) << $urandom_range(0, MISR_W - 1), 1'b0, -1);
    run_exec('0, '0, 1'b0, -1);

    // Reset at win_cnt == 2, then rst together with start stays idle
    fill(30, NUM_FF - 1);
    run_exec('0, '0, 1'b0, 2);
    cyc(1'b1, 1'b1, 1'b1, SEL_W'(1), '0, '0);
    cyc(1'b0, 1'b0, 1'b1, SEL_W'(1), '0, '0);

    // Back-to-back in-range requests on every RUN cycle
    fill(100, NUM_FF - 1);
    run_exec('0, '0, 1'b0, -1);

    // Randomized runs: mixed requests, selects, expectations, noise and aborts
    for (int r = 0; r < 60; r++) begin
      fill($urandom_range(0, 100), (1 << SEL_W) - 1);
      run_exec(($urandom_range(0, 2) == 0) ? MISR_W'($urandom) : '0,
               ($urandom_range(0, 2) == 0) ? MISR_W'($urandom) : '0,
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, WINDOW - 1)) : -1);
      repeat ($urandom_range(0, 2))
        cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), SEL_W'($urandom), IN_W'($urandom), OUT_W'($urandom));
    end

    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(cq.size() + rq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
